// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - external memory bus between dmem_responder and memory
interface dmem_responder_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - M-stage data port responder with FIFO store buffer
module dmem_responder #(
  parameter int SB_DEPTH = 4,
  parameter int SB_AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memtoregM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  dmem_responder_if.master bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RDONE} state_t;

  state_t           state;
  logic [29:0]      sbAddr [SB_DEPTH];
  logic [31:0]      sbData [SB_DEPTH];
  logic [SB_AW-1:0] head;
  logic [SB_AW-1:0] tail;
  logic [SB_AW:0]   count;
  logic [31:0]      rdbuf;

  logic             busReq;
  logic             busWe;
  logic [31:0]      busAddr;
  logic [31:0]      busWdata;

  logic             isStore;
  logic             isLoad;
  logic             sbFull;
  logic             storeAccept;
  logic             pop;
  logic             hit;
  logic [31:0]      hitData;
  logic             loadMiss;
  logic             unusedByteOffset;

  // A simultaneous load+store request is treated as a store.
  assign isStore     = memwriteM;
  assign isLoad      = memtoregM & ~memwriteM;
  assign sbFull      = (count == (SB_AW+1)'(SB_DEPTH));
  assign storeAccept = isStore & ~sbFull;
  assign pop         = (state == WRITE) & busReq & bus.bus_ack;
  assign loadMiss    = isLoad & ~hit & (state != RDONE);

  // Only the word address matters; the byte offset is intentionally dropped.
  assign unusedByteOffset = &{1'b0, aluoutM[1:0]};

  assign bus.bus_req   = busReq;
  assign bus.bus_we    = busWe;
  assign bus.bus_addr  = busAddr;
  assign bus.bus_wdata = busWdata;

  // Forwarding search: walk oldest to youngest so the youngest match wins.
  always_comb begin
    hit     = 1'b0;
    hitData = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (((SB_AW+1)'(i) < count) &&
          (sbAddr[head + SB_AW'(i)] == aluoutM[31:2])) begin
        hit     = 1'b1;
        hitData = sbData[head + SB_AW'(i)];
      end
    end
  end

  // Stall on a full buffer store or an unresolved load miss; never during reset.
  always_comb begin
    stallM = 1'b0;
    if (reset) begin
      stallM = (isStore & sbFull) | loadMiss;
    end
  end

  // Load data: captured miss data in RDONE, otherwise forwarded buffer data on a hit.
  always_comb begin
    readdataM = '0;
    if (state == RDONE) begin
      readdataM = rdbuf;
    end else if (isLoad && hit) begin
      readdataM = hitData;
    end
  end

  // Store buffer storage; occupancy is tracked by count so no reset is needed here.
  always_ff @(posedge clk) begin
    if (storeAccept) begin
      sbAddr[tail] <= aluoutM[31:2];
      sbData[tail] <= writedataM;
    end
  end

  // Pointers, occupancy and the bus FSM with its registered bus outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      rdbuf    <= '0;
      busReq   <= 1'b0;
      busWe    <= 1'b0;
      busAddr  <= '0;
      busWdata <= '0;
    end else begin
      if (storeAccept) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      count <= count + {{SB_AW{1'b0}}, storeAccept} - {{SB_AW{1'b0}}, pop};

      case (state)
        IDLE: begin
          if (loadMiss) begin
            // Misses win over draining so the pipeline restarts sooner.
            state   <= READ;
            busReq  <= 1'b1;
            busWe   <= 1'b0;
            busAddr <= {aluoutM[31:2], 2'b00};
          end else if (count != '0) begin
            state    <= WRITE;
            busReq   <= 1'b1;
            busWe    <= 1'b1;
            busAddr  <= {sbAddr[head], 2'b00};
            busWdata <= sbData[head];
          end
        end
        WRITE: begin
          // An outstanding write always completes, even if a miss is waiting.
          if (bus.bus_ack) begin
            busReq <= 1'b0;
            state  <= IDLE;
          end
        end
        READ: begin
          if (bus.bus_ack) begin
            rdbuf  <= bus.bus_rdata;
            busReq <= 1'b0;
            state  <= RDONE;
          end
        end
        RDONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder for the pipeline's M-stage data port. Accepts loads and stores from the core and buffers stores in a small FIFO store buffer.
- Drains buffered stores, and fetches load misses, over a single-outstanding req/ack external memory bus.
- Adds a stallM output; the hazard unit will consume it to freeze the pipeline while a load miss or a full-buffer store is pending.

Parameters:
SB_DEPTH, 4, store buffer entries (power of two, >=2)
SB_AW, 2, log2(SB_DEPTH)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-low reset
memtoregM  in  1  load request this cycle
memwriteM  in  1  store request this cycle
aluoutM  in  32  byte address; word index = aluoutM[31:2]
writedataM  in  32  store data
readdataM  out  32  load data
stallM  out  1  core must hold the M-stage request
bus_req  out  1  external transaction request, registered
bus_we  out  1  1=write, 0=read, registered
bus_addr  out  32  word address, [1:0]=00, registered
bus_wdata  out  32  write data, registered
bus_rdata  in  32  read data, valid with bus_ack on a read
bus_ack  in  1  transaction completes at posedge where bus_req&bus_ack

Behaviour:
- Reset (reset=0, async):
  - State IDLE; head, tail and count = 0.
  - bus_req, bus_we, bus_addr and bus_wdata = 0.
  - stallM=0; readdataM=0 while memtoregM=0.
  - Any bus transaction in flight is abandoned; buffered stores are discarded.
- Request decode: memwriteM&memtoregM together is illegal; treat it as a store.
- Store path:
  - A store is accepted at posedge iff count<SB_DEPTH at cycle start. It writes {addr[31:2], data} at tail; tail and count advance.
  - If count==SB_DEPTH, stallM=1 (combinational) and nothing is accepted. This holds even if a drain pops in the same cycle; acceptance happens next cycle.
  - Simultaneous accept and pop: count unchanged.
- Load path:
  - readdataM is combinational. The youngest valid buffer entry whose word address matches supplies the data: hit, stallM=0, in any FSM state.
  - Miss: stallM=1 until state RDONE.
  - readdataM=0 when no load is present and the state is not RDONE.
- FSM, states IDLE / WRITE / READ / RDONE:
  - IDLE + load miss -> READ. Latch addr; bus_req=1, bus_we=0, bus_addr={addr[31:2],2'b00}. A load miss has priority over starting a drain.
  - IDLE + count>0 + no load miss -> WRITE. Drive head entry; bus_req=1, bus_we=1.
  - WRITE: hold bus outputs stable until ack. On ack, pop head (head+1 mod SB_DEPTH, count-1), bus_req=0, -> IDLE.
    - A load miss arriving during WRITE stays stalled; the outstanding write is never aborted.
  - READ: hold bus outputs until ack. On ack, capture bus_rdata into rdbuf, bus_req=0, -> RDONE.
  - RDONE: stallM=0, readdataM=rdbuf; next posedge -> IDLE.
  - A drain issued after RDONE may start no earlier than the IDLE cycle.
- Load-miss latency: data is presented in the cycle after the read ack; minimum 2 cycles after entering READ.
- Pointers wrap modulo SB_DEPTH.
- Ordering: buffered stores reach the bus in FIFO order. A load miss never bypasses a same-address store; a miss implies no match in the buffer.
- bus_ack with bus_req=0 is ignored.

Test Plan:
1. Reset, store 0x10<=0xDEADBEEF with bus_ack=0, next cycle load 0x10 -> readdataM=0xDEADBEEF same cycle, stallM=0.
2. Stores 0x20<=0x1111, then 0x20<=0x2222 (bus_ack=0), then load 0x22 -> readdataM=0x2222, no stall.
3. bus_ack=0: 4 stores accepted, 5th -> stallM=1. Pulse bus_ack once -> bus saw write addr of store 1. The following cycle stallM=0 and the 5th store is accepted. Drained data order is stores 1..5.
4. Empty buffer, load 0x40 miss, bus acks 3 cycles after bus_req with 0xCAFEF00D -> stallM=1 through the ack cycle. Next cycle readdataM=0xCAFEF00D, stallM=0, then IDLE.
5. Load miss while a WRITE is outstanding -> bus_req stays a write until ack. The read req follows with bus_we=0, and no further drain starts before RDONE.
6. reset low during READ -> bus_req=0 and stallM=0 immediately. After release, count=0 and no bus activity.
